// File: rtl/data_sram_responder.sv
// Data-memory responder: word-addressed RAM with byte enables behind an in-order,
// fixed-latency response queue (req/addr_ok accept, one-cycle data_ok pulse).
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  // Countdown loaded at push: the entry retires LATENCY-1 edges after its accept edge.
  localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam bit BYPASS = (LATENCY == 1);

  logic [31:0]           mem    [2**ADDR_WIDTH];
  logic [31:0]           q_data [DEPTH];
  logic [3:0]            q_cnt  [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [OCC_W-1:0]      occ;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rd_word;
  logic [31:0]           wr_word;
  logic                  accept;
  logic                  push;
  logic                  retire;
  logic                  direct;
  logic                  unused_bits;

  assign unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

  assign idx     = addr[ADDR_WIDTH+1:2];
  assign rd_word = mem[idx];
  assign addr_ok = (occ < OCC_W'(DEPTH));
  assign accept  = req & addr_ok;
  // With single-cycle latency and nothing queued, the response skips the queue.
  assign direct  = BYPASS && accept && (occ == '0);
  assign push    = accept & ~direct;
  assign retire  = (occ != '0) && (q_cnt[head] == 4'd0);

  always_comb begin
    wr_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) wr_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (resetn && accept && wr) mem[idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (q_cnt[i] != 4'd0) q_cnt[i] <= q_cnt[i] - 4'd1;
    end
    if (push) begin
      q_cnt[tail]  <= CNT_INIT;
      q_data[tail] <= wr ? 32'h0 : rd_word;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      data_ok <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      data_ok <= retire | direct;
      if (retire) begin
        rdata <= q_data[head];
        head  <= head + 1'b1;
      end else if (direct) begin
        rdata <= wr ? 32'h0 : rd_word;
      end
      if (push) tail <= tail + 1'b1;
      case ({push, retire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder (slave) end of the data-memory request/response interface driven by the EX/MEM stages of the LoongArch pipeline.
- Accepts read and write requests with an address handshake (`req`/`addr_ok`) and returns in-order responses with a one-cycle `data_ok` pulse.
- Has configurable fixed latency and a bounded outstanding-request queue.
- Backs a word-addressed RAM with byte write enables; the MEM stage performs byte/half extraction on `rdata`.

Parameters:
- ADDR_WIDTH, 10, word-index bits; RAM holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, minimum cycles from request acceptance to its `data_ok`; legal range 1..15.
- DEPTH, 4, maximum outstanding accepted-but-unanswered requests; power of two, 2..16.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 byte, 1 half, 2 word; informational, not used by the RAM.
- wstrb  in  4  byte write enables, lane i = wdata[8i+7:8i].
- addr  in  32  byte address; word index = addr[ADDR_WIDTH+1:2]; other bits ignored.
- wdata  in  32  write data, already lane-aligned by the requester.
- addr_ok  out  1  request accepted this cycle when req & addr_ok.
- data_ok  out  1  one-cycle response pulse, oldest outstanding request.
- rdata  out  32  read data, valid while data_ok; 0 for write responses.

Behaviour:
- Reset (async, resetn=0):
  - Queue emptied and occupancy cleared; all outstanding requests are discarded and never answered.
  - Outputs during and after reset: addr_ok=1, data_ok=0, rdata=0.
  - RAM contents are not reset and are preserved across reset.
- Acceptance:
  - addr_ok = (occupancy < DEPTH), computed from registered occupancy only, with no combinational path from req.
  - addr_ok stays low when full even in a cycle where a response retires.
  - At most one acceptance per cycle.
- Write on accept:
  - RAM word is updated at that clock edge, for each lane where wstrb[i]=1.
  - An entry {is_write=1, data=0} is pushed.
- Read on accept:
  - The RAM word is sampled at acceptance, so it reflects all previously accepted writes.
  - The entry {is_write=0, data=word} is pushed.
- Timing:
  - A request accepted in cycle c produces data_ok in cycle max(c+LATENCY, previous data_ok cycle + 1).
  - Each entry carries its own countdown; the head retires when its countdown has expired.
  - Responses are strictly in acceptance order, at most one per cycle.
- Output rules:
  - data_ok and rdata are registered.
  - data_ok is a single-cycle pulse per response; there is no backpressure and the requester must accept it.
  - rdata holds its last value between pulses; rdata is 0 on write responses.
- Occupancy:
  - Push only: +1. Retire only: -1. Push and retire in the same cycle: unchanged.
  - The pointers wrap modulo DEPTH.
- Full throughput: with DEPTH ≥ LATENCY and req held high, one acceptance and one response per cycle in steady state.
- Illegal stimulus:
  - req with wr=1 and wstrb=0 is accepted, modifies nothing, and is answered.
  - Inputs are don't-care when req=0.

Test Plan:
- Write and read back, LATENCY=2:
  - Stimulus: reset, then write addr 0x10, wdata 0x12345678, wstrb 1111 in cycle 0; read addr 0x10 in cycle 1.
  - Response: addr_ok=1 throughout; data_ok in cycle 2 with rdata=0 (write), and in cycle 3 with rdata=0x12345678.
- Partial write:
  - Stimulus: write addr 0x12, wstrb 0100, wdata 0x00AB0000; then read addr 0x10.
  - Response: rdata=0x12AB5678 (addr[1:0] ignored by the RAM).
- Streaming reads, LATENCY=2, DEPTH=4:
  - Stimulus: req held for 4 reads of 0x0, 0x4, 0x8, 0xC (preloaded 1, 2, 3, 4).
  - Response: addr_ok never drops; data_ok high in 4 consecutive cycles with rdata 1, 2, 3, 4 in order.
- Full queue, LATENCY=8, DEPTH=4:
  - Stimulus: 5 back-to-back reads.
  - Response: first 4 accepted in cycles 0–3; addr_ok=0 from cycle 4; first data_ok in cycle 8; 5th request accepted only after that retirement; 5 responses total, in order.
- Reset mid-operation:
  - Stimulus: two reads outstanding, resetn pulled low asynchronously between edges.
  - Response: data_ok=0 immediately and addr_ok=1; no response for either read after resetn rises; a subsequent read of a previously written word returns the old data.
- Write-then-read same address in consecutive cycles:
  - Stimulus: write 0xDEADBEEF to 0x20, then read 0x20.
  - Response: the read response returns 0xDEADBEEF.
